// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
//
// Handshake (valid/ready semantics for the whole block):
//   - start is a one-shot request. It is taken on a rising edge only while
//     busy=0, meaning the unit is in IDLE or DONE. While busy=1, start is
//     ignored and the operands are not re-read.
//   - done is a one-cycle pulse. result is valid in that cycle and stays
//     unchanged until the next done pulse.
//   - flush cancels whatever is in flight on the next edge. It suppresses
//     done and wins over a start in the same cycle.
//
// Signals:
//   start   request (master -> slave)
//   op      funct3 of the M instruction (master -> slave)
//   srcA    rs1 operand (master -> slave)
//   srcB    rs2 operand (master -> slave)
//   flush   squash the in-flight operation (master -> slave)
//   busy    operation in progress; the pipeline stalls (slave -> master)
//   done    one-cycle result-valid pulse (slave -> master)
//   result  registered result (slave -> master)
interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, srcA, srcB, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, srcA, srcB, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Multiplication uses radix-2 shift-add, one multiplier bit per cycle.
// Division uses restoring division, one quotient bit per cycle.
// Both work on operand magnitudes. The sign correction is applied in a
// single FIX cycle.
//
// Division special cases (divide by zero, signed overflow) are resolved
// when the operands are latched. They go straight to DONE.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        muldiv_unit_if slave (start/op/srcA/srcB/flush in,
//              busy/done/result out)
//   dbg_state  current FSM state: 0 IDLE, 1 CALC, 2 FIX, 3 DONE
module muldiv_unit (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus,
  output logic [1:0]    dbg_state
);

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_mag;      // multiplicand magnitude
  logic [XLEN-1:0]   b_mag;      // divisor magnitude
  logic [2*XLEN-1:0] prod;       // {accumulator, remaining multiplier bits}
  logic [XLEN-1:0]   rem;        // partial remainder
  logic [XLEN-1:0]   quo;        // dividend bits shifting out, quotient in
  logic              neg_res;    // negate the product/quotient
  logic              neg_rem;    // negate the remainder (dividend sign)
  logic [4:0]        cnt;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Operand preparation, evaluated on the request inputs at latch time.
  logic            a_signed;
  logic            b_signed;
  logic            neg_a_in;
  logic            neg_b_in;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed    = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed    = (bus.op == OP_MULH) || (bus.op == OP_DIV) ||
                  (bus.op == OP_REM);
    neg_a_in    = a_signed & bus.srcA[XLEN-1];
    neg_b_in    = b_signed & bus.srcB[XLEN-1];
    a_mag_in    = neg_a_in ? (32'd0 - bus.srcA) : bus.srcA;
    b_mag_in    = neg_b_in ? (32'd0 - bus.srcB) : bus.srcB;
    div_by_zero = bus.op[2] && (bus.srcB == 32'd0);
    div_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                  (bus.srcA == 32'h8000_0000) && (bus.srcB == 32'hFFFF_FFFF);
    special_res = '0;
    // op[1] separates REM/REMU from DIV/DIVU.
    if (div_by_zero) begin
      special_res = bus.op[1] ? bus.srcA : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = bus.op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step of each algorithm.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} +
                (prod[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
    div_shift = {rem, quo[XLEN-1]};
    // The partial remainder stays below the divisor, so the shifted value is
    // below 2*divisor. A set top bit therefore already means "fits".
    div_ge    = div_shift[XLEN] || (div_shift[XLEN-1:0] >= b_mag);
    div_sub   = div_shift[XLEN-1:0] - b_mag;
  end

  // Sign correction and output selection for the FIX cycle.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_res ? (64'd0 - prod) : prod;
    quo_fix  = neg_res ? (32'd0 - quo) : quo;
    rem_fix  = neg_rem ? (32'd0 - rem) : rem;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quo_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            neg_res <= neg_a_in ^ neg_b_in;
            neg_rem <= neg_a_in;
            cnt     <= '0;
            prod    <= {{XLEN{1'b0}}, b_mag_in};
            rem     <= '0;
            quo     <= a_mag_in;
            if (div_by_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (!op_q[2]) begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end else begin
            rem <= div_ge ? div_sub : div_shift[XLEN-1:0];
            quo <= {quo[XLEN-2:0], div_ge};
          end
          if (cnt == 5'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. The driver issues operations and pushes the
// expected result and the expected done cycle. A monitor pops both whenever
// done is seen. The expected values come from plain 64-bit and 32-bit
// integer arithmetic.
module tb_muldiv_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", 0);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = 32'd0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && ((b == 32'd0) ||
                    (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          qa, qb;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    qa = $signed(a);
    qb = $signed(b);
    r  = 32'd0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = qa / qb;
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = qa % qb;
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    int          d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result 0x%08h expected no done at cycle %0d",
                     bus.result, cyc);
          end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            check("result", bus.result, e);
            check("done_cycle", cyc, d);
            check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            last_exp = e;
          end
        end else if (due_q.size() != 0 && cyc > due_q[0]) begin
          checks++;
          errors++;
          $display("FAIL done_timeout: got no done expected one at cycle %0d", due_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Returns at the negedge following the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit track);
    int g = 0;
    while (bus.busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: got busy stuck expected idle at cycle %0d", cyc);
    end
    bus.start = 1'b1;
    bus.op    = o;
    bus.srcA  = a;
    bus.srcB  = b;
    @(posedge clk);
    #1;
    if (track) begin
      exp_q.push_back(ref_model(o, a, b));
      due_q.push_back(cyc + (is_special(o, a, b) ? 0 : 33));
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!bus.done && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done expected one at cycle %0d", cyc);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners[5];
    corners[0] = 32'd0;
    corners[1] = 32'd1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.srcA  = 32'd0;
    bus.srcB  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MUL with busy-length check
    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mul_busy_cycles", n, 33);
    wait_drain();

    // high multiplies and division
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 1'b1);
    wait_drain();

    // division special cases: 1-cycle latency and busy never rises
    issue(3'd4, 32'd5, 32'd0, 1'b1);
    check("special_busy_a", {31'd0, bus.busy}, 32'd0);
    issue(3'd7, 32'd5, 32'd0, 1'b1);
    check("special_busy_b", {31'd0, bus.busy}, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("special_busy_c", {31'd0, bus.busy}, 32'd0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("special_busy_d", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("special_busy_after", {31'd0, bus.busy}, 32'd0);
    wait_drain();

    // start with new operands while busy is ignored
    issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.op    = 3'd5;
      bus.srcA  = $urandom;
      bus.srcB  = $urandom_range(1, 1000);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_drain();

    // flush at CALC cycle 10, together with a start that must lose
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.srcA  = 32'd50;
    bus.srcB  = 32'd5;
    @(posedge clk);
    #1;
    check("flush_state", {30'd0, dbg_state}, 32'd0);
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_done", {31'd0, bus.done}, 32'd0);
    check("flush_result_kept", bus.result, last_exp);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    // reset in the middle of CALC
    issue(3'd4, 32'hDEAD_BEEF, 32'd13, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    check("midreset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    last_exp = 32'd0;
    repeat (40) @(negedge clk);

    // back-to-back: second start in the DONE cycle of the first
    issue(3'd0, 32'd3, 32'd4, 1'b1);
    wait_done();
    issue(3'd5, 32'd9, 32'd3, 1'b1);
    check("b2b_done_falls", {31'd0, bus.done}, 32'd0);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_drain();

    // randomized operations with random gaps
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      issue(o, a, b, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    repeat (5) @(negedge clk);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
